// File: rtl/rotary_input_conditioner_pkg.sv
// Shared types and constants for the rotary/button input conditioner.
// Quadrature FSM state codes, detent code and default debounce length.
package rotary_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CW1    = 3'd1,
    CW2    = 3'd2,
    CW3    = 3'd3,
    CCW1   = 3'd4,
    CCW2   = 3'd5,
    CCW3   = 3'd6,
    RESYNC = 3'd7
  } quad_state_e;

  localparam logic [1:0] DETENT = 2'b11;
  localparam int DEBOUNCE_DEFAULT = 1000;

endpackage

// File: rtl/rotary_input_conditioner_if.sv
// Raw pad inputs and conditioned pulse outputs of the conditioner.
// The slave side is the conditioner, the master side drives the pads.
interface rotary_input_conditioner_if;

  logic rotary_a;
  logic rotary_b;
  logic select_raw;
  logic restart_raw;
  logic step_up;
  logic step_down;
  logic select_press;
  logic restart_press;

  modport master (
    output rotary_a, rotary_b,
    output select_raw, restart_raw,
    input  step_up, step_down,
    input  select_press, restart_press
  );

  modport slave (
    input  rotary_a, rotary_b,
    input  select_raw, restart_raw,
    output step_up, step_down,
    output select_press, restart_press
  );

endinterface

// File: rtl/rotary_input_conditioner_debounce_filter.sv
// Two-flop synchroniser followed by a counting debounce filter.
// stable only follows the input after it has held the new level.
module debounce_filter
  import rotary_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

  logic          s1_q;
  logic          s2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // flip on the differing sample after LIMIT differing samples in a row
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == LIMIT) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= RESET_VALUE;
      s2_q     <= RESET_VALUE;
      stable_q <= RESET_VALUE;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/rotary_input_conditioner.sv
// Conditions encoder phases and pushbuttons into one-cycle pulses.
// Quadrature decoding and button edge detection live here.
module rotary_input_conditioner
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input logic clk,
  input logic rst,
  rotary_input_conditioner_if.slave bus
);

  logic        a_s;
  logic        b_s;
  logic        sel_s;
  logic        rs_s;
  logic [1:0]  ab;
  logic [1:0]  chg;
  logic [1:0]  ab_prev_q;

  quad_state_e state_q;
  quad_state_e state_d;

  logic up_d;
  logic up_q;
  logic dn_d;
  logic dn_q;
  logic sel_d;
  logic sel_q;
  logic rs_d;
  logic rs_q;
  logic sel_prev_q;
  logic rs_prev_q;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VALUE(1'b1)
  ) u_db_a (
    .clk(clk), .rst(rst),
    .raw(bus.rotary_a), .stable(a_s)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VALUE(1'b1)
  ) u_db_b (
    .clk(clk), .rst(rst),
    .raw(bus.rotary_b), .stable(b_s)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VALUE(1'b0)
  ) u_db_sel (
    .clk(clk), .rst(rst),
    .raw(bus.select_raw), .stable(sel_s)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VALUE(1'b0)
  ) u_db_rs (
    .clk(clk), .rst(rst),
    .raw(bus.restart_raw), .stable(rs_s)
  );

  assign ab  = {a_s, b_s};
  assign chg = ab ^ ab_prev_q;

  always_comb begin
    state_d = state_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    if (state_q == RESYNC) begin
      if (ab == DETENT) state_d = IDLE;
    end else if (chg == 2'b11) begin
      state_d = RESYNC;
    end else if (chg != 2'b00) begin
      unique case (state_q)
        IDLE: begin
          if (ab == 2'b10)      state_d = CW1;
          else if (ab == 2'b01) state_d = CCW1;
          else                  state_d = RESYNC;
        end
        CW1: begin
          if (ab == 2'b00)        state_d = CW2;
          else if (ab == DETENT)  state_d = IDLE;
          else                    state_d = RESYNC;
        end
        CW2: begin
          if (ab == 2'b01)      state_d = CW3;
          else if (ab == 2'b10) state_d = CW1;
          else                  state_d = RESYNC;
        end
        CW3: begin
          if (ab == DETENT) begin
            state_d = IDLE;
            up_d    = 1'b1;
          end else if (ab == 2'b00) begin
            state_d = CW2;
          end else begin
            state_d = RESYNC;
          end
        end
        CCW1: begin
          if (ab == 2'b00)       state_d = CCW2;
          else if (ab == DETENT) state_d = IDLE;
          else                   state_d = RESYNC;
        end
        CCW2: begin
          if (ab == 2'b10)      state_d = CCW3;
          else if (ab == 2'b01) state_d = CCW1;
          else                  state_d = RESYNC;
        end
        CCW3: begin
          if (ab == DETENT) begin
            state_d = IDLE;
            dn_d    = 1'b1;
          end else if (ab == 2'b00) begin
            state_d = CCW2;
          end else begin
            state_d = RESYNC;
          end
        end
        default: state_d = RESYNC;
      endcase
    end
  end

  assign sel_d = sel_s & ~sel_prev_q;
  assign rs_d  = rs_s & ~rs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ab_prev_q  <= DETENT;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      sel_q      <= 1'b0;
      rs_q       <= 1'b0;
      sel_prev_q <= 1'b0;
      rs_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ab_prev_q  <= ab;
      up_q       <= up_d;
      dn_q       <= dn_d;
      sel_q      <= sel_d;
      rs_q       <= rs_d;
      sel_prev_q <= sel_s;
      rs_prev_q  <= rs_s;
    end
  end

  assign bus.step_up       = up_q;
  assign bus.step_down     = dn_q;
  assign bus.select_press  = sel_q;
  assign bus.restart_press = rs_q;

endmodule

// File: tb/tb_rotary_input_conditioner.sv
// Scoreboard bench: window-based debounce and detent-displacement model
// predicts pulses; a negedge monitor compares them with the DUT.
module tb_rotary_input_conditioner;

  localparam int D = 4;
  localparam logic [3:0] RV = 4'b0011;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rotary_input_conditioner_if bus();

  rotary_input_conditioner #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  typedef struct {
    string name;
    int    got;
    int    exp;
  } chk_t;

  exp_t sb_q[$];
  chk_t chk_q[$];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int n_up = 0, n_dn = 0, n_sel = 0, n_rs = 0;
  int last_up = -1, last_sel = -1, last_rs = -1;

  logic [D+2:0] hist [4];
  logic         st [4];
  logic [3:0]   pend = '0;
  int           disp = 0;
  bit           resync = 0;

  function automatic int pos(logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b10:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(int p);
    case (p)
      0:       return 2'b11;
      1:       return 2'b10;
      2:       return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int outv();
    return int'({bus.restart_press, bus.select_press,
                 bus.step_down, bus.step_up});
  endfunction

  // Reference model: stable flips once the last D+1 synchronised
  // samples all disagree; detents are tracked as signed displacement.
  always @(posedge clk) begin : model
    logic [3:0] raw;
    logic [3:0] out;
    logic [1:0] old_ab;
    logic [1:0] new_ab;
    bit         diff;
    int         dlt;
    cyc++;
    raw = {bus.restart_raw, bus.select_raw, bus.rotary_b, bus.rotary_a};
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hist[i] = {(D+3){RV[i]}};
        st[i]   = RV[i];
      end
      disp   = 0;
      resync = 0;
      pend   = '0;
    end else begin
      if (pend != '0) sb_q.push_back('{cyc, pend});
      out    = '0;
      old_ab = {st[0], st[1]};
      for (int i = 0; i < 4; i++) begin
        hist[i] = {hist[i][D+1:0], raw[i]};
        diff = 1;
        for (int k = 2; k <= D + 2; k++)
          if (hist[i][k] == st[i]) diff = 0;
        if (diff) begin
          st[i] = ~st[i];
          if (i >= 2 && st[i]) out[i] = 1'b1;
        end
      end
      new_ab = {st[0], st[1]};
      if (resync) begin
        if (new_ab == 2'b11) begin
          resync = 0;
          disp   = 0;
        end
      end else if (new_ab != old_ab) begin
        dlt = (pos(new_ab) - pos(old_ab) + 4) % 4;
        if (dlt == 2) begin
          resync = 1;
        end else begin
          disp += (dlt == 1) ? 1 : -1;
          if (disp == 4) begin
            out[0] = 1'b1;
            disp   = 0;
          end
          if (disp == -4) begin
            out[1] = 1'b1;
            disp   = 0;
          end
        end
      end
      pend = out;
    end
  end

  always @(negedge clk) begin : monitor
    logic [3:0] got;
    got = {bus.restart_press, bus.select_press,
           bus.step_down, bus.step_up};
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      compared++;
      if (got !== sb_q[0].val) begin
        mismatched++;
        $display("FAIL pulses cyc=%0d got=%b exp=%b",
                 cyc, got, sb_q[0].val);
      end
      void'(sb_q.pop_front());
    end else if (got !== 4'b0000) begin
      compared++;
      mismatched++;
      $display("FAIL pulses cyc=%0d got=%b exp=0000", cyc, got);
    end
    if (got[0] === 1'b1) begin n_up++;  last_up  = cyc; end
    if (got[1] === 1'b1) n_dn++;
    if (got[2] === 1'b1) begin n_sel++; last_sel = cyc; end
    if (got[3] === 1'b1) begin n_rs++;  last_rs  = cyc; end
    while (chk_q.size() > 0) begin
      compared++;
      if (chk_q[0].got != chk_q[0].exp) begin
        mismatched++;
        $display("FAIL %s got=%0d exp=%0d",
                 chk_q[0].name, chk_q[0].got, chk_q[0].exp);
      end
      void'(chk_q.pop_front());
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(string name, int got, int exp);
    chk_q.push_back('{name, got, exp});
  endtask

  task automatic set_ab(logic [1:0] ab, int hold);
    bus.rotary_a = ab[1];
    bus.rotary_b = ab[0];
    tick(hold);
  endtask

  initial begin
    int u0, d0, s0, r0, t, p, dir, r;
    bus.rotary_a    = 1'b1;
    bus.rotary_b    = 1'b1;
    bus.select_raw  = 1'b0;
    bus.restart_raw = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      tick(1);
      check("rst_out", outv(), 0);
      check("rst_fsm", int'(dut.state_q), 0);
    end
    rst = 1'b0;
    u0 = n_up; d0 = n_dn; s0 = n_sel; r0 = n_rs;
    tick(20);
    check("idle_quiet", n_up + n_dn + n_sel + n_rs - u0 - d0 - s0 - r0, 0);

    // clockwise detent
    u0 = n_up; d0 = n_dn;
    set_ab(2'b10, 12);
    set_ab(2'b00, 12);
    set_ab(2'b01, 12);
    t = cyc + 1;
    set_ab(2'b11, 12);
    check("cw_up", n_up - u0, 1);
    check("cw_dn", n_dn - d0, 0);
    check("cw_lat", last_up, t + 7);

    // counter-clockwise with backtrack
    u0 = n_up; d0 = n_dn;
    set_ab(2'b01, 12);
    set_ab(2'b00, 12);
    set_ab(2'b01, 12);
    set_ab(2'b00, 12);
    set_ab(2'b10, 12);
    set_ab(2'b11, 12);
    check("ccw_dn", n_dn - d0, 1);
    check("ccw_up", n_up - u0, 0);

    // partial step and return
    u0 = n_up; d0 = n_dn;
    set_ab(2'b10, 12);
    set_ab(2'b11, 12);
    check("back_quiet", n_up + n_dn - u0 - d0, 0);

    // short glitch on A, then an illegal jump
    u0 = n_up; d0 = n_dn;
    set_ab(2'b01, 3);
    set_ab(2'b11, 12);
    check("glitch_fsm", int'(dut.state_q), 0);
    set_ab(2'b00, 12);
    check("jump_fsm", int'(dut.state_q), 7);
    set_ab(2'b11, 12);
    check("jump_idle", int'(dut.state_q), 0);
    check("jump_quiet", n_up + n_dn - u0 - d0, 0);

    // select press and bounce
    s0 = n_sel;
    t = cyc + 1;
    bus.select_raw = 1'b1;
    tick(10);
    bus.select_raw = 1'b0;
    tick(12);
    check("sel_cnt", n_sel - s0, 1);
    check("sel_lat", last_sel, t + 7);
    s0 = n_sel;
    for (int i = 0; i < 10; i++) begin
      bus.select_raw = ~bus.select_raw;
      tick(2);
    end
    bus.select_raw = 1'b0;
    tick(12);
    check("bounce", n_sel - s0, 0);

    // restart press coinciding with a completed detent
    u0 = n_up; r0 = n_rs;
    set_ab(2'b10, 12);
    set_ab(2'b00, 12);
    set_ab(2'b01, 12);
    bus.restart_raw = 1'b1;
    set_ab(2'b11, 12);
    bus.restart_raw = 1'b0;
    tick(12);
    check("coin_up", n_up - u0, 1);
    check("coin_rs", n_rs - r0, 1);
    check("coin_cyc", last_rs, last_up);

    // reset in the middle of a detent
    u0 = n_up;
    set_ab(2'b10, 12);
    set_ab(2'b00, 12);
    check("mid_cw2", int'(dut.state_q), 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_out", outv(), 0);
    check("mid_fsm", int'(dut.state_q), 0);
    set_ab(2'b01, 12);
    set_ab(2'b11, 12);
    check("mid_noup", n_up - u0, 0);
    set_ab(2'b10, 12);
    set_ab(2'b00, 12);
    set_ab(2'b01, 12);
    set_ab(2'b11, 12);
    check("mid_full", n_up - u0, 1);

    // randomized walk with jumps, bounces and resets
    p = 0;
    dir = 1;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end else if (r < 8) begin
        p = (p + 2) % 4;
      end else if (r < 75) begin
        if ($urandom_range(0, 7) == 0) dir = -dir;
        p = (p + dir + 4) % 4;
      end
      if ($urandom_range(0, 3) == 0) bus.select_raw = ~bus.select_raw;
      if ($urandom_range(0, 3) == 0) bus.restart_raw = ~bus.restart_raw;
      set_ab(ab_of(p), $urandom_range(1, 14));
    end
    bus.select_raw  = 1'b0;
    bus.restart_raw = 1'b0;
    set_ab(2'b11, 40);
    check("sb_drained", sb_q.size(), 0);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
